opendap_ap_mux: RTL

//  Sits between opendap_sw_dp AP bus and up to N_APS access points. Decodes ap_sel,

---
 rtl/opendap_ap_mux.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/opendap_ap_mux.sv
// opendap_ap_mux: routes DP AP-bus accesses to one of N_APS access points and returns its response.
// Optional busy timeout is enabled by defining OPENDAP_AP_MUX_TIMEOUT_EN.
module opendap_ap_mux #(
  parameter int unsigned N_APS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  swclk,
  input  logic                  rst_n,
  input  logic [7:0]            ap_sel,
  input  logic [5:0]            ap_addr,
  input  logic [31:0]           ap_wdata,
  input  logic                  ap_wen,
  input  logic                  ap_ren,
  input  logic                  ap_abort,
  output logic [31:0]           ap_rdata,
  output logic                  ap_rdy,
  output logic                  ap_err,
  output logic [5:0]            dn_addr,
  output logic [31:0]           dn_wdata,
  output logic [N_APS-1:0]      dn_wen,
  output logic [N_APS-1:0]      dn_ren,
  output logic [N_APS-1:0]      dn_abort,
  input  logic [32*N_APS-1:0]   dn_rdata,
  input  logic [N_APS-1:0]      dn_rdy,
  input  logic [N_APS-1:0]      dn_err
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SEL_LIM = 8'(N_APS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_nxt;
  logic        w_start;
  logic        w_mapped;
  logic        w_timeout;
  logic        w_sel_rdy;
  logic        w_sel_err;
  logic [31:0] w_sel_rdata;

  assign dn_addr  = ap_addr;
  assign dn_wdata = ap_wdata;
  assign w_start  = (r_state == IDLE) && (ap_wen || ap_ren) && !ap_abort;
  assign w_mapped = ap_sel < SEL_LIM;

`ifdef OPENDAP_AP_MUX_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Busy-cycle counter, restarted by every accepted access
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_unused_cfg = ^(CNT_W'(TIMEOUT_CYCLES));
`endif

  // Response of the AP latched at start
  always_comb begin
    w_sel_rdy   = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int k = 0; k < int'(N_APS); k++) begin
      if (r_idx == 4'(k)) begin
        w_sel_rdy   = dn_rdy[k];
        w_sel_err   = dn_err[k];
        w_sel_rdata = dn_rdata[32*k +: 32];
      end
    end
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    ap_rdy      = 1'b1;
    ap_err      = 1'b0;
    ap_rdata    = '0;
    dn_wen      = '0;
    dn_ren      = '0;
    dn_abort    = '0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_mapped) begin
            for (int k = 0; k < int'(N_APS); k++) begin
              if (ap_sel == 8'(k)) begin
                dn_wen[k] = ap_wen;
                dn_ren[k] = ap_ren && !ap_wen;
              end
            end
            w_idx_nxt   = ap_sel[3:0];
            w_state_nxt = BUSY;
          end else begin
            w_state_nxt = ERR;
          end
        end
      end
      BUSY: begin
        ap_rdy   = w_sel_rdy;
        ap_err   = w_sel_err;
        ap_rdata = w_sel_rdata;
        if (w_sel_rdy) begin
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          for (int k = 0; k < int'(N_APS); k++) begin
            if (r_idx == 4'(k)) begin
              dn_abort[k] = 1'b1;
            end
          end
          w_state_nxt = ERR;
        end
      end
      ERR: begin
        ap_err      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start
    if (ap_abort) begin
      dn_abort    = '1;
      w_state_nxt = IDLE;
    end
  end

endmodule
